// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/shift ops plus an iterative shift-add multiply.
module alu_seq #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             err,
  output logic             cmp
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [3:0] F_ADD = 4'b0101;
  localparam logic [3:0] F_SUB = 4'b0100;
  localparam logic [3:0] F_SHL = 4'b1110;
  localparam logic [3:0] F_SHR = 4'b0111;
  localparam logic [3:0] F_XOR = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0011;
  localparam logic [3:0] F_OR  = 4'b0010;
  localparam logic [3:0] F_CMP = 4'b0110;
  localparam logic [3:0] F_DSH = 4'b1010;
  localparam logic [3:0] F_MUL = 4'b1000;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic             live;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0]   step;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_err;
  logic [PW-1:0]    acc_nxt;

  // live gates in_ready low for the cycle right after reset
  assign in_ready = live && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; shifts by >= WIDTH naturally yield zero
  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_err   = 1'b0;
    sum     = {1'b0, x} + {1'b0, y};
    diff    = {1'b0, x} - {1'b0, y};
    case (funct)
      F_ADD: begin
        c_res   = sum[WIDTH-1:0];
        c_carry = sum[WIDTH];
      end
      F_SUB: begin
        c_res   = diff[WIDTH-1:0];
        c_carry = diff[WIDTH];
      end
      F_SHL: c_res = x << y;
      F_SHR: c_res = x >> y;
      F_XOR: c_res = x ^ y;
      F_AND: c_res = x & y;
      F_OR:  c_res = x | y;
      F_CMP: c_res = x;
      F_DSH: c_res = y[SHW] ? (x >> y[SHW-1:0]) : (x << y[SHW-1:0]);
      F_MUL: c_res = '0;
      default: c_err = 1'b1;
    endcase
  end

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      live      <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
      cmp       <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (funct == F_MUL) begin
              mcand     <= {{WIDTH{1'b0}}, x};
              mplier    <= y;
              acc       <= '0;
              step      <= '0;
              out_valid <= 1'b0;
              state     <= MUL;
            end else begin
              result    <= c_res;
              result_hi <= '0;
              carry     <= c_carry;
              zero      <= (c_res == '0);
              err       <= c_err;
              out_valid <= 1'b1;
              if (funct == F_CMP) cmp <= (x == y);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + SHW'(1);
          if (step == SHW'(WIDTH - 1)) begin
            result    <= acc_nxt[WIDTH-1:0];
            result_hi <= acc_nxt[PW-1:WIDTH];
            carry     <= 1'b0;
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake corner
// sequences, randomized ops against an arithmetic model, and a WIDTH=16 instance.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] x, y, result, result_hi;
  logic [3:0] funct;
  logic       carry, zero, err, cmp;

  logic        v16, rdy16, ov16;
  logic [15:0] x16, y16, r16, h16;
  logic [3:0]  f16;
  logic        c16, z16, e16, cm16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
    .err(err), .cmp(cmp)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .x(x16), .y(y16), .funct(f16), .out_valid(ov16), .out_ready(1'b1),
    .result(r16), .result_hi(h16), .carry(c16), .zero(z16),
    .err(e16), .cmp(cm16)
  );

  typedef struct {
    logic [3:0] f;
    logic [7:0] a, b, res, hi;
    logic       c, z, e, cm;
    string      nm;
  } vec_t;

  typedef struct {
    logic [7:0] res, hi;
    logic       c, z, e;
  } exp_t;

  vec_t vecs[19];
  logic exp_cmp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference computed from the operation definitions with integer arithmetic
  function automatic exp_t model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int ai, bi, v, amt;
    ai = int'(a);
    bi = int'(b);
    r.hi = 8'h00; r.c = 1'b0; r.e = 1'b0; v = 0;
    case (f)
      4'b0101: begin v = ai + bi; r.c = (v > 255); end
      4'b0100: begin v = ai - bi; r.c = (ai < bi); end
      4'b1110: v = (bi >= 8) ? 0 : ai * (1 << bi);
      4'b0111: v = (bi >= 8) ? 0 : ai / (1 << bi);
      4'b0001: v = int'(a ^ b);
      4'b0011: v = int'(a & b);
      4'b0010: v = int'(a | b);
      4'b0110: v = ai;
      4'b1010: begin
        amt = bi % 8;
        v = (((bi / 8) % 2) == 1) ? ai / (1 << amt) : ai * (1 << amt);
      end
      4'b1000: begin
        v = ai * bi;
        r.hi = 8'((v / 256) % 256);
      end
      default: begin v = 0; r.e = 1'b1; end
    endcase
    r.res = 8'(v % 256 + (v < 0 ? 256 : 0));
    r.z   = (r.res == 8'h00);
    return r;
  endfunction

  task automatic check_out(input string nm, input exp_t e, input logic cm);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".res"},   32'(result),    32'(e.res));
    chk({nm, ".hi"},    32'(result_hi), 32'(e.hi));
    chk({nm, ".carry"}, 32'(carry),     32'(e.c));
    chk({nm, ".zero"},  32'(zero),      32'(e.z));
    chk({nm, ".err"},   32'(err),       32'(e.e));
    chk({nm, ".cmp"},   32'(cmp),       32'(cm));
  endtask

  // Offer an op and return #1 after its accept edge; operands then scrambled
  task automatic send(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    funct = f; x = a; y = b; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = ~a; y = ~b; funct = ~f;
  endtask

  // Wait for completion and check latency; in_ready must stay low in MUL
  task automatic wait_done(input string nm, input bit is_mul);
    int cyc;
    bit rdy_low;
    cyc = 1;
    rdy_low = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, ".latency"}, 32'(cyc), is_mul ? 32'd9 : 32'd1);
    if (is_mul) chk({nm, ".ready_low_in_mul"}, 32'(rdy_low), 32'd1);
  endtask

  task automatic op16(input string nm, input logic [3:0] f, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] er, input logic ee);
    int n;
    n = 0;
    @(negedge clk);
    f16 = f; x16 = a; y16 = b; v16 = 1'b1;
    while (!rdy16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy16) chk({nm, ".accept_timeout"}, 32'(rdy16), 32'd1);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    chk({nm, ".valid"}, 32'(ov16), 32'd1);
    chk({nm, ".res"},   32'(r16),  32'(er));
    chk({nm, ".err"},   32'(e16),  32'(ee));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [3:0] rf;
    logic [7:0] ra, rb, hold;
    int k;

    vecs[0]  = '{4'b0101, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "add_carry"};
    vecs[1]  = '{4'b0100, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "sub_zero"};
    vecs[2]  = '{4'b0100, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "sub_borrow"};
    vecs[3]  = '{4'b0101, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "add_wrap"};
    vecs[4]  = '{4'b0110, 8'h07, 8'h07, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "cmp_eq"};
    vecs[5]  = '{4'b0001, 8'hAA, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "xor"};
    vecs[6]  = '{4'b0011, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "and"};
    vecs[7]  = '{4'b0010, 8'hF0, 8'h0C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "or"};
    vecs[8]  = '{4'b1110, 8'h81, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "shl1"};
    vecs[9]  = '{4'b1110, 8'h81, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "shl_full"};
    vecs[10] = '{4'b0111, 8'h80, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "shr7"};
    vecs[11] = '{4'b0111, 8'hFF, 8'hC8, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "shr_big"};
    vecs[12] = '{4'b1010, 8'h80, 8'h0B, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "dsh_right"};
    vecs[13] = '{4'b1010, 8'h21, 8'hF2, 8'h84, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "dsh_left"};
    vecs[14] = '{4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, "mul_ff"};
    vecs[15] = '{4'b1000, 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, "mul_256"};
    vecs[16] = '{4'b1111, 8'h05, 8'h06, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, "illegal_f"};
    vecs[17] = '{4'b0000, 8'h09, 8'h09, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, "illegal_0"};
    vecs[18] = '{4'b0110, 8'h03, 8'h04, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "cmp_ne"};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; funct = '0;
    v16 = 1'b0; x16 = '0; y16 = '0; f16 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    e = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.res",   32'(result),    32'd0);
    chk("rst.hi",    32'(result_hi), 32'd0);
    chk("rst.flags", 32'({carry, zero, err, cmp}), 32'd0);
    chk("rst.ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst.ready_first_cycle", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst.ready_after", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      send(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].nm, vecs[i].f == 4'b1000);
      e = '{vecs[i].res, vecs[i].hi, vecs[i].c, vecs[i].z, vecs[i].e};
      check_out(vecs[i].nm, e, vecs[i].cm);
    end

    // Back-to-back ops, one accepted per cycle
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; funct = 4'b0100; x = 8'h05; y = 8'h05;
    @(posedge clk); #1;
    chk("b2b.sub.res", 32'(result), 32'h00);
    chk("b2b.sub.zero", 32'(zero), 32'd1);
    funct = 4'b0110; x = 8'h07; y = 8'h07;
    @(posedge clk); #1;
    chk("b2b.cmp.res", 32'(result), 32'h07);
    chk("b2b.cmp.cmp", 32'(cmp), 32'd1);
    funct = 4'b0001; x = 8'hAA; y = 8'hAA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.xor.res", 32'(result), 32'h00);
    chk("b2b.xor.zero", 32'(zero), 32'd1);
    chk("b2b.xor.cmp_held", 32'(cmp), 32'd1);
    chk("b2b.valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("b2b.drained", 32'(out_valid), 32'd0);

    // Backpressure: result holds, then drain and accept in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; funct = 4'b0101; x = 8'h01; y = 8'h02;
    @(posedge clk); #1;
    chk("bp.valid", 32'(out_valid), 32'd1);
    chk("bp.res", 32'(result), 32'h03);
    chk("bp.ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold.res", 32'(result), 32'h03);
      chk("bp.hold.valid", 32'(out_valid), 32'd1);
      chk("bp.hold.ready", 32'(in_ready), 32'd0);
    end
    funct = 4'b0010; x = 8'h0F; y = 8'h30; out_ready = 1'b1;
    #1;
    chk("bp.ready_on_drain", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.next.valid", 32'(out_valid), 32'd1);
    chk("bp.next.res", 32'(result), 32'h3F);

    // Reset in the middle of a multiply
    send(4'b1000, 8'h0F, 8'h0F);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.cmp", 32'(cmp), 32'd0);
    chk("mrst.res", 32'(result), 32'd0);
    chk("mrst.ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("mrst.no_output", 32'(out_valid), 32'd0);
    end
    send(4'b0101, 8'h02, 8'h03);
    wait_done("mrst.add", 1'b0);
    check_out("mrst.add", '{8'h05, 8'h00, 1'b0, 1'b0, 1'b0}, 1'b0);

    // Randomized ops against the model, with occasional stalls
    exp_cmp = 1'b0;
    for (int i = 0; i < 150; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      send(rf, ra, rb);
      wait_done("rnd", rf == 4'b1000);
      e = model(rf, ra, rb);
      if (rf == 4'b0110) exp_cmp = (ra == rb);
      check_out("rnd", e, exp_cmp);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        hold = e.res;
        k = $urandom_range(1, 4);
        for (int j = 0; j < k; j++) begin
          @(posedge clk); #1;
          chk("rnd.stall.res", 32'(result), 32'(hold));
          chk("rnd.stall.valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
    end

    // WIDTH=16 shifts and illegal code
    op16("w16.dsh", 4'b1010, 16'h8000, 16'h0013, 16'h1000, 1'b0);
    op16("w16.shl16", 4'b1110, 16'hFFFF, 16'd16, 16'h0000, 1'b0);
    op16("w16.shl3", 4'b1110, 16'h0101, 16'd3, 16'h0808, 1'b0);
    op16("w16.illegal", 4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b1);
    chk("w16.zero", 32'(z16), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's 8-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered result with flags. All original function codes are kept, shift ops are generalised to any `WIDTH`, and an iterative multiply is added. It sits between register-file read and writeback, so the pipeline can stall on multi-cycle ops.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH), shift-amount field width (derived, do not override).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted this cycle when `in_valid && in_ready`.
- `x`, `y` in WIDTH: operands.
- `funct` in 4: operation code.
- `out_valid` out 1: result registers hold a completed operation.
- `out_ready` in 1: consumer takes the result when `out_valid && out_ready`.
- `result` out WIDTH: result (low half for multiply).
- `result_hi` out WIDTH: high half of the multiply product; 0 for all other ops.
- `carry` out 1: add carry-out, or sub borrow (x < y unsigned); 0 otherwise.
- `zero` out 1: `result == 0`.
- `err` out 1: funct was not a legal code.
- `cmp` out 1: sticky compare flag.

## Operation
- Function codes:
  - 0101 add; 0100 sub.
  - 1110 `x << y`; 0111 `x >> y` (logical, full y; amount ≥ WIDTH gives 0).
  - 0001 xor; 0011 and; 0010 or.
  - 0110 compare: result = x; `cmp` register ← (x == y).
  - 1010 directional shift: y[SHW]=1 gives `x >> y[SHW-1:0]`, else `x << y[SHW-1:0]`; higher y bits ignored.
  - 1000 unsigned multiply: {result_hi, result} = x*y, 2·WIDTH bits.
  - Any other code: result = 0, `err` = 1, completes as single-cycle.
- State machine:
  - IDLE: `in_ready = !out_valid || out_ready`.
  - On accept of a non-multiply op: compute and load the result registers, set `out_valid`, stay IDLE.
  - On accept of 1000: load multiplicand, multiplier and a zeroed 2·WIDTH accumulator, clear the step counter, go MUL.
  - MUL: `in_ready` = 0. Perform one shift-add step per cycle, WIDTH steps. On the last step load the result registers, set `out_valid`, return to IDLE.
- Output registers hold steady while `out_valid && !out_ready`.
- `out_valid` clears on the handshake unless a new op is accepted in the same cycle; that op's completion then overwrites the registers.
- `cmp` changes only when a 0110 op completes; it holds its value across all other ops and handshakes.
- `carry`, `zero`, `err` and `result_hi` are reloaded on every completion.

## Timing
- Reset (`rst_n` = 0 at an edge) forces all of the following to 0: `out_valid`, `result`, `result_hi`, `carry`, `zero`, `err`, `cmp`, `in_ready`, state = IDLE.
  - `in_ready` then follows the IDLE rule from the next cycle.
- Reset during MUL aborts the multiply with no output produced.
- Non-multiply latency is 1: the result is visible the cycle after the accept edge. Throughput is 1 op/cycle with `out_ready` held high.
- Multiply latency is WIDTH+1 cycles from the accept cycle to `out_valid`. No new op is accepted until the multiply completes.
- MUL finishing while an earlier result is still stalled cannot occur, because accept requires the output slot free or draining.
- Inputs are sampled only on the accept edge. Changes to x, y or funct afterward have no effect.

## Test plan
- Reset then add: x=8'hF0, y=8'h20, `out_ready`=1 → next cycle result=8'h10, carry=1, zero=0, out_valid=1.
- Back-to-back: sub 5-5, then cmp 7,7, then xor 8'hAA^8'hAA, one per cycle → results 0/zero=1, 7/cmp=1, 0/zero=1 on consecutive cycles; `cmp` stays 1 after the xor.
- Multiply, WIDTH=8: x=8'hFF, y=8'hFF → after exactly 9 cycles result=8'h01, result_hi=8'hFE; `in_ready`=0 throughout MUL.
- Backpressure: `out_ready`=0 with `in_valid` held high → one op completes, `in_ready` drops, outputs stable for 5 cycles; raising `out_ready` drains it and accepts the next op in the same cycle.
- Shifts, WIDTH=16: 1010 with y=5'b1_0011 on x=16'h8000 → 16'h1000; 1110 with y=16 → 0; funct 1111 → result 0, err=1.
- Reset mid-multiply at step 3 → out_valid stays 0, `cmp` = 0, next add completes normally.
